// File: rtl/irq_ctrl.sv
// Single-level interrupt controller placed in front of status_reg.
// Synchronises the external lines, latches rising edges as pending bits and
// requests entry from the control unit. On entry it saves the status word and
// masks interrupts and enters SUPERVISOR. On return it restores the saved word.
package irq_ctrl_pkg;
  typedef enum logic {
    USER       = 1'b0,
    SUPERVISOR = 1'b1
  } cpu_mode_e;

  typedef struct packed {
    logic [3:0] alu_status;
    logic       imask;
    cpu_mode_e  mode;
  } status_t;
endpackage

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int VW      = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  status_t            status_value,
  input  logic               int_ack,
  input  logic               rti,
  output logic               int_req,
  output logic [VW-1:0]      int_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               ld,
  output status_t            status_in,
  output logic               ld_imask,
  output logic               imask_in,
  output logic               ld_mode,
  output cpu_mode_e          mode_in
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_ENTER   = 3'd2;
  localparam logic [2:0] S_HANDLER = 3'd3;
  localparam logic [2:0] S_RETURN  = 3'd4;

  logic [2:0]         state_reg;
  status_t            shadow_reg;
  logic [NUM_IRQ-1:0] sync1_reg;
  logic [NUM_IRQ-1:0] sync2_reg;
  logic [NUM_IRQ-1:0] prev_reg;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [VW-1:0]      prio_idx;

  // Two-flop synchroniser plus previous-value flop for edge detection.
  // prev resets to 0 so a line already high at reset release counts as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_rise
      assign rise[gi] = sync2_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

  // Lowest-index pending line wins: scan from the top so the last hit is lowest.
  always_comb begin
    prio_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) prio_idx = VW'(i);
    end
  end

  // The acknowledged line is cleared only in the accepting cycle.
  always_comb begin
    clr_mask = '0;
    if (state_reg == S_REQ && int_ack) clr_mask[int_vector] = 1'b1;
  end

  // Pending bits accumulate in every state; a fresh edge beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr_mask) | rise;
  end

  // Sequencer: request, entry strobes, handler wait, restore strobe.
  // All load strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      shadow_reg <= '0;
      int_req    <= 1'b0;
      int_vector <= '0;
      ld         <= 1'b0;
      status_in  <= '0;
      ld_imask   <= 1'b0;
      imask_in   <= 1'b0;
      ld_mode    <= 1'b0;
      mode_in    <= USER;
    end else begin
      ld        <= 1'b0;
      status_in <= '0;
      ld_imask  <= 1'b0;
      imask_in  <= 1'b0;
      ld_mode   <= 1'b0;
      mode_in   <= USER;
      case (state_reg)
        S_IDLE: begin
          if (|pending && !status_value.imask) begin
            state_reg  <= S_REQ;
            int_req    <= 1'b1;
            int_vector <= prio_idx;
          end
        end
        S_REQ: begin
          // Ack takes precedence over a simultaneous mask.
          if (int_ack) begin
            state_reg  <= S_ENTER;
            shadow_reg <= status_value;
            int_req    <= 1'b0;
            ld_imask   <= 1'b1;
            imask_in   <= 1'b1;
            ld_mode    <= 1'b1;
            mode_in    <= SUPERVISOR;
          end else if (status_value.imask) begin
            state_reg <= S_IDLE;
            int_req   <= 1'b0;
          end
        end
        S_ENTER: begin
          state_reg <= S_HANDLER;
        end
        S_HANDLER: begin
          if (rti) begin
            state_reg <= S_RETURN;
            ld        <= 1'b1;
            status_in <= shadow_reg;
          end
        end
        S_RETURN: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          int_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NUM_IRQ = 4;
  localparam int VW      = $clog2(NUM_IRQ);

  logic               clk;
  logic               rst;
  logic [NUM_IRQ-1:0] irq;
  status_t            sv;
  logic               int_ack;
  logic               rti;
  logic               int_req;
  logic [VW-1:0]      int_vector;
  logic [NUM_IRQ-1:0] pending;
  logic               ld;
  status_t            status_in;
  logic               ld_imask;
  logic               imask_in;
  logic               ld_mode;
  cpu_mode_e          mode_in;

  irq_ctrl #(.NUM_IRQ(NUM_IRQ), .VW(VW)) dut (
    .clk(clk), .rst(rst), .irq(irq), .status_value(sv),
    .int_ack(int_ack), .rti(rti),
    .int_req(int_req), .int_vector(int_vector), .pending(pending),
    .ld(ld), .status_in(status_in),
    .ld_imask(ld_imask), .imask_in(imask_in),
    .ld_mode(ld_mode), .mode_in(mode_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit perturb_en = 1'b0;

  // Behavioural model: interrupt life cycle phases and expected outputs.
  typedef enum {WAITING, REQUESTING, ENTERING, SERVICING, RETURNING} phase_e;
  phase_e             m_phase;
  logic [NUM_IRQ-1:0] smp [3];     // irq as seen at the last three edges
  logic [NUM_IRQ-1:0] m_pending;
  logic               m_req;
  int                 m_vec;
  status_t            m_shadow;
  logic               m_ld;
  status_t            m_status_in;
  logic               m_ld_imask;
  logic               m_imask_in;
  logic               m_ld_mode;
  cpu_mode_e          m_mode_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Isolate the lowest set bit arithmetically, then take its position.
  function automatic int lowest_set(input logic [NUM_IRQ-1:0] p);
    logic [NUM_IRQ-1:0] iso;
    iso = p & (~p + 1'b1);
    return $clog2(iso);
  endfunction

  task automatic model_reset();
    m_phase = WAITING;
    for (int i = 0; i < 3; i++) smp[i] = '0;
    m_pending = '0; m_req = 1'b0; m_vec = 0; m_shadow = '0;
    m_ld = 1'b0; m_status_in = '0; m_ld_imask = 1'b0; m_imask_in = 1'b0;
    m_ld_mode = 1'b0; m_mode_in = USER;
  endtask

  // One rising edge: an edge is an irq level seen two edges ago that was low three edges ago.
  task automatic model_step();
    logic [NUM_IRQ-1:0] new_edges;
    logic [NUM_IRQ-1:0] taken;
    new_edges = smp[1] & ~smp[2];
    smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = irq;
    taken = '0;
    m_ld = 1'b0; m_status_in = '0; m_ld_imask = 1'b0; m_imask_in = 1'b0;
    m_ld_mode = 1'b0; m_mode_in = USER;
    case (m_phase)
      WAITING: if (m_pending != 0 && !sv.imask) begin
        m_phase = REQUESTING; m_req = 1'b1; m_vec = lowest_set(m_pending);
      end
      REQUESTING: if (int_ack) begin
        m_shadow = sv;
        taken = NUM_IRQ'(1) << m_vec;
        m_req = 1'b0; m_phase = ENTERING;
        m_ld_imask = 1'b1; m_imask_in = 1'b1; m_ld_mode = 1'b1; m_mode_in = SUPERVISOR;
        $display("ack: vector=%0d saved_status=%0h pending=%b t=%0t", m_vec, m_shadow, m_pending, $time);
      end else if (sv.imask) begin
        m_req = 1'b0; m_phase = WAITING;
      end
      ENTERING: m_phase = SERVICING;
      SERVICING: if (rti) begin
        m_phase = RETURNING; m_ld = 1'b1; m_status_in = m_shadow;
      end
      RETURNING: m_phase = WAITING;
      default: m_phase = WAITING;
    endcase
    m_pending = (m_pending & ~taken) | new_edges;
  endtask

  task automatic check_all();
    check_eq("int_req",    32'(int_req),    32'(m_req));
    check_eq("int_vector", 32'(int_vector), 32'(m_vec));
    check_eq("pending",    32'(pending),    32'(m_pending));
    check_eq("ld",         32'(ld),         32'(m_ld));
    check_eq("status_in",  32'(status_in),  32'(m_status_in));
    check_eq("ld_imask",   32'(ld_imask),   32'(m_ld_imask));
    check_eq("imask_in",   32'(imask_in),   32'(m_imask_in));
    check_eq("ld_mode",    32'(ld_mode),    32'(m_ld_mode));
    check_eq("mode_in",    32'(mode_in),    32'(m_mode_in));
  endtask

  // Advance one clock; emulate status_reg updating one edge after the strobes.
  task automatic tick();
    logic      pl, pli, pii, plm;
    status_t   ps;
    cpu_mode_e pmi;
    @(posedge clk);
    pl = m_ld; ps = m_status_in; pli = m_ld_imask; pii = m_imask_in;
    plm = m_ld_mode; pmi = m_mode_in;
    model_step();
    @(negedge clk);
    check_all();
    if (pl) sv = ps;
    else begin
      if (pli) sv.imask = pii;
      if (plm) sv.mode = pmi;
    end
    if (perturb_en && !m_ld && !m_ld_imask && !m_ld_mode) begin
      if ($urandom_range(0, 3) == 0) sv.alu_status = 4'($urandom);
      if ($urandom_range(0, 9) == 0) sv.imask = ~sv.imask;
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!m_req && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(m_req), 32'(1));
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pulse_rti();
    rti = 1'b1; tick(); rti = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    status_t base;
    base = '{alu_status: 4'b1010, imask: 1'b0, mode: USER};
    rst = 1'b0; irq = '0; sv = base; int_ack = 1'b0; rti = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;

    // Single irq on line 2.
    irq = 4'b0100; tick(); irq = '0;
    tick(); tick();
    check_eq("pend_after_3_edges", 32'(pending), 32'(4'b0100));
    tick();
    check_eq("req_line2", 32'(int_req), 32'(1));
    check_eq("vec_line2", 32'(int_vector), 32'(2));

    // Ack and entry strobes.
    pulse_ack();
    check_eq("enter_ld_imask", 32'(ld_imask), 32'(1));
    check_eq("enter_mode_in", 32'(mode_in), 32'(SUPERVISOR));
    check_eq("enter_pending", 32'(pending), 32'(0));
    check_eq("enter_req", 32'(int_req), 32'(0));
    tick();
    check_eq("enter_one_cycle", 32'(ld_imask), 32'(0));
    tick();

    // Return restores the saved word.
    pulse_rti();
    check_eq("ret_ld", 32'(ld), 32'(1));
    check_eq("ret_status", 32'(status_in), 32'(base));
    tick();
    check_eq("ret_one_cycle", 32'(ld), 32'(0));

    // Priority and accumulation during the handler.
    irq = 4'b1010; tick(); irq = '0;
    wait_req("prio_wait1");
    check_eq("prio_vec1", 32'(int_vector), 32'(1));
    pulse_ack(); tick();
    irq = 4'b0001; tick(); irq = '0;
    repeat (4) tick();
    pulse_rti();
    wait_req("prio_wait0");
    check_eq("prio_vec0", 32'(int_vector), 32'(0));
    pulse_ack(); tick(); pulse_rti();
    wait_req("prio_wait3");
    check_eq("prio_vec3", 32'(int_vector), 32'(3));
    pulse_ack(); tick(); pulse_rti(); tick();

    // Masking.
    sv.imask = 1'b1;
    irq = 4'b0010; tick(); irq = '0;
    repeat (6) tick();
    check_eq("masked_no_req", 32'(int_req), 32'(0));
    check_eq("masked_pending", 32'(pending), 32'(4'b0010));
    sv.imask = 1'b0;
    wait_req("unmask_wait");
    check_eq("unmask_vec", 32'(int_vector), 32'(1));
    sv.imask = 1'b1; tick();
    check_eq("withdraw_req", 32'(int_req), 32'(0));
    check_eq("withdraw_pending", 32'(pending), 32'(4'b0010));
    sv.imask = 1'b0;
    wait_req("reassert_wait");
    check_eq("reassert_req", 32'(int_req), 32'(1));
    pulse_ack(); tick(); tick();

    // Asynchronous reset in the handler.
    #2 rst = 1'b0;
    #1;
    check_eq("arst_req", 32'(int_req), 32'(0));
    check_eq("arst_pending", 32'(pending), 32'(0));
    check_eq("arst_vec", 32'(int_vector), 32'(0));
    check_eq("arst_ld", 32'(ld), 32'(0));
    check_eq("arst_status_in", 32'(status_in), 32'(0));
    check_eq("arst_ld_imask", 32'(ld_imask), 32'(0));
    check_eq("arst_ld_mode", 32'(ld_mode), 32'(0));
    model_reset();
    sv = base;
    @(negedge clk);
    rti = 1'b1; int_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    rti = 1'b0; int_ack = 1'b0;
    tick();
    check_eq("stray_no_ld", 32'(ld), 32'(0));

    // Random traffic against the model.
    perturb_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM_IRQ; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      int_ack = ($urandom_range(0, 2) == 0);
      rti     = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller sitting directly upstream of `status_reg`. It synchronises and latches external interrupt lines and requests entry from the control unit, gated by the status imask bit. On entry it saves the full status word to a shadow register and drives `status_reg`'s imask/mode load ports to mask interrupts and enter SUPERVISOR. On return-from-interrupt it reloads the saved status word through `status_reg`'s full `ld`/`in` port. Single-level: no nesting.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of interrupt lines, 2..16.
- `VW`, `$clog2(NUM_IRQ)`: vector width.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `irq` in NUM_IRQ: asynchronous interrupt lines, rising-edge events.
- `status_value` in `status_t`: current status word from `status_reg`; `imask`=1 means masked.
- `int_ack` in 1: control unit accepts the request at an instruction boundary.
- `rti` in 1: one-cycle return-from-interrupt pulse.
- `int_req` out 1: interrupt request to control unit.
- `int_vector` out VW: index of the requested line.
- `pending` out NUM_IRQ: latched pending bits.
- `ld` out 1, `status_in` out `status_t`: full status load to `status_reg`.
- `ld_imask` out 1, `imask_in` out 1: imask load.
- `ld_mode` out 1, `mode_in` out `cpu_mode_e`: mode load.

## Operation
- Per line: 2-flop synchroniser plus one previous-value flop. A sync 0→1 transition sets `pending[i]`.
- Priority: lowest pending index wins.
- Pending bits accumulate in every state. A bit is cleared only on ack of that index. If a new edge arrives on the same line in the ack cycle, set wins.
- FSM states: IDLE, REQ, ENTER, HANDLER, RETURN. All outputs are registered.
- IDLE → REQ when `|pending && !status_value.imask`.
  - On this transition `int_vector` latches the priority index and `int_req` rises.
  - `int_vector` is held stable throughout REQ.
- REQ, `int_ack`=1 → ENTER.
  - `shadow <= status_value`.
  - Clear `pending[int_vector]`.
  - `int_req` falls.
- REQ, no ack, `status_value.imask`=1 → IDLE: request withdrawn, `int_req` falls, pending untouched.
- If ack and imask rise together, ack wins.
- ENTER (one cycle) → HANDLER.
  - `ld_imask`=1, `imask_in`=1.
  - `ld_mode`=1, `mode_in`=SUPERVISOR.
- HANDLER → RETURN on `rti`.
- RETURN (one cycle) → IDLE.
  - `ld`=1, `status_in`=shadow: restores alu_status, imask and mode.
- `int_ack` outside REQ and `rti` outside HANDLER are ignored.
- When `ld`, `ld_imask` and `ld_mode` are all 0, `status_in`, `imask_in` and `mode_in` drive 0/USER.
- The control unit does not load `status_reg` in ENTER or RETURN cycles.

## Timing
- Reset (rst=0, asynchronous) sets:
  - state IDLE; `pending`=0, `shadow`=0, `int_vector`=0;
  - sync and previous-value flops 0;
  - all load strobes 0; `int_req`=0.
- A line already high at reset release counts as one edge.
- Irq latency: `irq` rising before edge E0 sets `pending` after E2 (sync at E0, E1; detect at E2). `int_req` goes high after E3 if unmasked.
- Ack latency: ack sampled at edge A gives ENTER strobes during A→A+1; `status_reg` updates at A+1.
- Rti latency: rti sampled at edge R gives `ld` during R→R+1; status restored at R+1. Earliest new `int_req` is after R+2.
- Reset asserted mid-handler aborts immediately: shadow is lost, no restore.

## Test plan
- Reset then single irq: `status_value` imask=0, mode=USER, alu_status=4'b1010; pulse `irq[2]` → `pending`=4'b0100 after 3 edges, `int_req`=1, `int_vector`=2 the next cycle.
- Ack and entry: from the previous scenario, assert `int_ack` one cycle → next cycle `ld_imask`=1/`imask_in`=1 and `ld_mode`=1/`mode_in`=SUPERVISOR, each for exactly one cycle; `pending`=0, `int_req`=0.
- Return: in HANDLER pulse `rti` → one cycle `ld`=1, `status_in` = alu_status 4'b1010, imask 0, mode USER; state back to IDLE.
- Priority and accumulation: raise `irq[3]` and `irq[1]` together → vector 1. During the handler pulse `irq[0]` → after return the next request has vector 0, followed by vector 3.
- Masking: `status_value.imask`=1 with `pending`≠0 → `int_req` stays 0. Set imask=1 while in REQ with no ack → `int_req` drops next cycle, pending kept. Clear imask → request reasserts.
- Async reset mid-HANDLER: drop `rst` between edges → all outputs 0 and `pending`=0 immediately, no `ld` pulse; a stray `rti`/`int_ack` afterwards has no effect.
